wb_intercon: RTL and testbench

//  Parametrised single-master, N-slave Wishbone classic interconnect between the cpu and its peripherals.
//  - Decodes the master address against per-slave base/mask windows.
//  - Routes strobe only to the selected slave and muxes that slave's data and response back to the master.
//  - Terminates unmapped accesses with an error; optionally terminates unresponsive slaves after a timeout.
//  - Replaces shared-bus data wiring and OR'd acks in SoC tops.

---
 rtl/wb_intercon.sv | 140 ++++++++++++++
 tb/tb_wb_intercon.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_intercon.sv
// Single-master, N-slave Wishbone classic interconnect with base/mask address decode; define WB_INTERCON_TIMEOUT_EN for the slave watchdog.
// Latency: slave strobe 1 cycle after request, slave response forwarded combinationally, unmapped error 2 cycles after request.
// Backpressure: the master waits on the selected slave's ack/err/rty; dropping m_cyc_i aborts the cycle immediately.
module wb_intercon #(
    parameter int unsigned                NUM_SLAVES     = 2,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = '0,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = '0,
    parameter int unsigned                TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    input  logic [31:0]                  m_adr_i,
    input  logic [3:0]                   m_sel_i,
    input  logic [31:0]                  m_dat_i,
    input  logic                         m_we_i,
    output logic [31:0]                  m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic                         m_rty_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    output logic [31:0]                  s_adr_o,
    output logic [3:0]                   s_sel_o,
    output logic [31:0]                  s_dat_o,
    output logic                         s_we_o,
    input  logic [NUM_SLAVES*32-1:0]     s_dat_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    input  logic [NUM_SLAVES-1:0]        s_err_i,
    input  logic [NUM_SLAVES-1:0]        s_rty_i
);

    localparam int unsigned GW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        DEC_WAIT = 2'd2,
        ERR      = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;

`ifdef WB_INTERCON_TIMEOUT_EN
    logic [15:0]     count;
`endif

    assign s_adr_o = m_adr_i;
    assign s_sel_o = m_sel_i;
    assign s_dat_o = m_dat_i;
    assign s_we_o  = m_we_i;

    // Descending scan so the lowest matching window is the one left standing.
    logic            hit;
    logic [GW-1:0]   hit_idx;
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_adr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = GW'(i);
            end
        end
    end

    logic            g_ack;
    logic            g_err;
    logic            g_rty;
    logic            g_resp;
    logic [31:0]     g_dat;
    logic            busy_act;
    logic [NUM_SLAVES-1:0] grant_vec;

    assign g_ack    = s_ack_i[grant];
    assign g_err    = s_err_i[grant];
    assign g_rty    = s_rty_i[grant];
    assign g_dat    = s_dat_i[32*grant +: 32];
    assign g_resp   = g_ack | g_err | g_rty;
    assign busy_act = (state == BUSY) && m_cyc_i;

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            grant_vec[i] = (grant == GW'(i));
        end
    end

    // Responses are gated by m_cyc_i so an aborted cycle never answers the master.
    assign s_cyc_o = busy_act ? grant_vec : '0;
    assign s_stb_o = (busy_act && m_stb_i) ? grant_vec : '0;
    assign m_dat_o = busy_act ? g_dat : 32'h0;
    assign m_ack_o = busy_act & g_ack;
    assign m_err_o = (busy_act & g_err & ~g_ack) | (state == ERR);
    assign m_rty_o = busy_act & g_rty & ~g_ack & ~g_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            grant <= '0;
`ifdef WB_INTERCON_TIMEOUT_EN
            count <= 16'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        if (hit) begin
                            grant <= hit_idx;
                            state <= BUSY;
`ifdef WB_INTERCON_TIMEOUT_EN
                            count <= 16'h0;
`endif
                        end else begin
                            state <= DEC_WAIT;
                        end
                    end
                end
                BUSY: begin
                    if (!m_cyc_i || g_resp) begin
                        state <= IDLE;
`ifdef WB_INTERCON_TIMEOUT_EN
                    end else if (count == 16'(TIMEOUT_CYCLES - 1)) begin
                        // Leaving BUSY drops the slave strobe; ERR answers the master.
                        state <= ERR;
                    end else begin
                        count <= count + 16'h1;
`endif
                    end
                end
                DEC_WAIT: state <= ERR;
                ERR:      state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_intercon.sv
// Randomized transaction bench for wb_intercon (2 slaves) with a transaction-level expectation model.
`timescale 1ns/1ps
module tb_wb_intercon;

    localparam int N  = 2;
    localparam int TO = 8;
    localparam logic [63:0] BASE = {32'h4000_0000, 32'h1000_0000};
    localparam logic [63:0] MASK = {32'hFFFF_FFF0, 32'hFFFF_C000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
    logic [31:0] m_adr_i = '0, m_dat_i = '0;
    logic [3:0]  m_sel_i = '0;
    logic [31:0] m_dat_o;
    logic        m_ack_o, m_err_o, m_rty_o;
    logic [N-1:0] s_cyc_o, s_stb_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o;
    logic [N*32-1:0] s_dat_i = '0;
    logic [N-1:0] s_ack_i = '0, s_err_i = '0, s_rty_i = '0;

    wb_intercon #(
        .NUM_SLAVES(N), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i),
        .m_dat_i(m_dat_i), .m_we_i(m_we_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o),
        .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    logic [N-1:0] exp_s_stb, exp_s_cyc;
    logic         exp_ack, exp_err, exp_rty;
    logic [31:0]  exp_dat;

    int first_stb, stb_cycles, ack_cyc, err_cyc, err_cnt;
    logic [31:0] ack_dat, obs_sdat;
    logic [3:0]  obs_sel;
    logic [N-1:0] first_stb_val;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_stb_o", 64'(s_stb_o), 64'(exp_s_stb));
            check("s_cyc_o", 64'(s_cyc_o), 64'(exp_s_cyc));
            check("m_ack_o", 64'(m_ack_o), 64'(exp_ack));
            check("m_err_o", 64'(m_err_o), 64'(exp_err));
            check("m_rty_o", 64'(m_rty_o), 64'(exp_rty));
            check("m_dat_o", 64'(m_dat_o), 64'(exp_dat));
            check("bcast", {s_adr_o, s_dat_o}, {m_adr_i, m_dat_i});
            check("bcast_sel_we", 64'({s_sel_o, s_we_o}), 64'({m_sel_i, m_we_i}));
        end
    end

    function automatic int decode(logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & MASK[32*i +: 32]) == BASE[32*i +: 32]) return i;
        return -1;
    endfunction

    task automatic exp_zero();
        exp_s_stb = '0; exp_s_cyc = '0;
        exp_ack = 1'b0; exp_err = 1'b0; exp_rty = 1'b0; exp_dat = '0;
    endtask

    // Random slave chatter; the granted slave (g >= 0) stays quiet unless told otherwise.
    task automatic garbage(int g);
        s_dat_i = {$urandom, $urandom};
        s_ack_i = N'($urandom);
        s_err_i = N'($urandom);
        s_rty_i = N'($urandom);
        if (g >= 0) begin
            s_ack_i[g] = 1'b0; s_err_i[g] = 1'b0; s_rty_i[g] = 1'b0;
        end
    endtask

    task automatic step(int k);
        @(negedge clk);
        if (s_stb_o != '0) begin
            if (first_stb < 0) begin
                first_stb = k; first_stb_val = s_stb_o; obs_sel = s_sel_o; obs_sdat = s_dat_o;
            end
            stb_cycles++;
        end
        if (m_ack_o) begin ack_cyc = k; ack_dat = m_dat_o; end
        if (m_err_o) begin err_cyc = k; err_cnt++; end
        @(posedge clk);
        #1;
    endtask

    // One master transaction: request at cycle 0, slave answers with kind
    // {rty,err,ack} in BUSY cycle d, master drops cyc in cycle abort_at (0 = never).
    task automatic do_txn(logic [31:0] adr, logic we, logic [3:0] sel, logic [31:0] dat,
                          int d, logic [2:0] kind, int abort_at, logic use_rdat, logic [31:0] rdat);
        int g;
        g = decode(adr);
        first_stb = -1; stb_cycles = 0; ack_cyc = -1; err_cyc = -1; err_cnt = 0;
        ack_dat = '0; obs_sdat = '0; obs_sel = '0; first_stb_val = '0;
        m_adr_i = adr; m_we_i = we; m_sel_i = sel; m_dat_i = dat;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        garbage(-1); exp_zero();
        step(0);
        if (g < 0) begin
            garbage(-1); exp_zero(); step(1);
            garbage(-1); exp_zero(); exp_err = 1'b1; step(2);
        end else begin
            for (int j = 1; j <= 2000; j++) begin
                garbage(g);
                if (use_rdat) s_dat_i[32*g +: 32] = rdat;
                exp_zero();
                if (j == abort_at) begin
                    m_cyc_i = 1'b0; m_stb_i = 1'b0;
                    step(j);
                    break;
                end
`ifdef WB_INTERCON_TIMEOUT_EN
                if (j == TO + 1) begin
                    exp_err = 1'b1;
                    step(j);
                    break;
                end
`endif
                exp_s_stb = N'(1 << g);
                exp_s_cyc = N'(1 << g);
                exp_dat   = s_dat_i[32*g +: 32];
                if (j == d) begin
                    s_ack_i[g] = kind[0]; s_err_i[g] = kind[1]; s_rty_i[g] = kind[2];
                    exp_ack = kind[0];
                    exp_err = kind[1] & ~kind[0];
                    exp_rty = kind[2] & ~kind[0] & ~kind[1];
                end
                step(j);
                if (j == d) break;
            end
        end
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        garbage(-1); exp_zero();
        step(99);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cat, d, ab;
        logic [31:0] adr;
        logic [2:0] kind;

        exp_zero();
        garbage(-1);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h4000_0000;
        #2;
        check("reset_outputs", {s_stb_o, s_cyc_o, m_ack_o, m_err_o, m_rty_o}, '0);
        check("reset_dat", 64'(m_dat_o), 64'h0);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // T1: read slave1, ack two cycles after its strobe
        do_txn(32'h4000_0004, 1'b0, 4'hF, 32'h0, 3, 3'b001, 0, 1'b1, 32'hDEAD_BEEF);
        check("t1_first_stb", first_stb, 1);
        check("t1_stb_val", 64'(first_stb_val), 64'(2'b10));
        check("t1_ack_cyc", ack_cyc, 3);
        check("t1_ack_dat", 64'(ack_dat), 64'hDEAD_BEEF);

        // T2: write slave0
        do_txn(32'h1000_0010, 1'b1, 4'b0011, 32'h0000_1234, 1, 3'b001, 0, 1'b0, 32'h0);
        check("t2_stb_val", 64'(first_stb_val), 64'(2'b01));
        check("t2_sel", 64'(obs_sel), 64'(4'b0011));
        check("t2_sdat", 64'(obs_sdat), 64'h1234);
        check("t2_ack_cyc", ack_cyc, 1);

        // T3: unmapped
        do_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0, 1, 3'b001, 0, 1'b0, 32'h0);
        check("t3_no_stb", first_stb, -1);
        check("t3_err_cyc", err_cyc, 2);
        check("t3_err_cnt", err_cnt, 1);

        // T4: silent slave1
`ifdef WB_INTERCON_TIMEOUT_EN
        do_txn(32'h4000_0008, 1'b0, 4'hF, 32'h0, 1000, 3'b001, 0, 1'b0, 32'h0);
        check("t4_stb_cycles", stb_cycles, TO);
        check("t4_err_cyc", err_cyc, TO + 1);
        check("t4_err_cnt", err_cnt, 1);
`else
        do_txn(32'h4000_0008, 1'b0, 4'hF, 32'h0, 1001, 3'b001, 1001, 1'b0, 32'h0);
        check("t4_stb_cycles", stb_cycles, 1000);
        check("t4_err_cnt", err_cnt, 0);
`endif

        // T5: abort in the second BUSY cycle, then a fresh request
        do_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 5, 3'b001, 2, 1'b0, 32'h0);
        check("t5_stb_cycles", stb_cycles, 1);
        check("t5_no_ack", ack_cyc, -1);
        check("t5_no_err", err_cnt, 0);
        do_txn(32'h1000_0100, 1'b0, 4'hF, 32'h0, 1, 3'b001, 0, 1'b0, 32'h0);
        check("t5_next_ack", ack_cyc, 1);

        // Response priority: ack+err+rty together reads as ack only
        do_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 2, 3'b111, 0, 1'b0, 32'h0);
        check("prio_ack", ack_cyc, 2);
        check("prio_no_err", err_cnt, 0);

        // T6: asynchronous reset mid-BUSY while slave1 is acking
        m_adr_i = 32'h4000_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        garbage(-1); exp_zero(); step(0);
        garbage(1); exp_zero(); exp_s_stb = 2'b10; exp_s_cyc = 2'b10;
        exp_dat = s_dat_i[63:32]; step(1);
        chk_en = 1'b0;
        garbage(1); s_ack_i[1] = 1'b1;
        #1;
        check("t6_pre_ack", 64'(m_ack_o), 64'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_ctl", {s_stb_o, s_cyc_o, m_ack_o, m_err_o, m_rty_o}, '0);
        check("t6_rst_dat", 64'(m_dat_o), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
        garbage(-1); exp_zero();
        chk_en = 1'b1;
        step(0);
        do_txn(32'h4000_000C, 1'b0, 4'hF, 32'h0, 1, 3'b001, 0, 1'b0, 32'h0);
        check("t6_after_ack", ack_cyc, 1);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            cat = $urandom_range(0, 2);
            if (cat == 0)      adr = 32'h1000_0000 | ($urandom & 32'h0000_3FFF);
            else if (cat == 1) adr = 32'h4000_0000 | ($urandom & 32'h0000_000F);
            else               adr = $urandom;
            d = $urandom_range(1, 12);
            kind = 3'($urandom_range(1, 7));
            ab = 0;
            if ($urandom_range(0, 5) == 0) ab = $urandom_range(1, (d > TO) ? TO : d);
            do_txn(adr, 1'($urandom), 4'($urandom), $urandom, d, kind, ab, 1'b0, 32'h0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
